serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes Diff = A − B − Bin, one bit per clock, LSB first.
- Built around a single full-subtractor cell and a borrow flip-flop.
- Complement block to the team's full-adder cells: the inverse arithmetic direction, made sequential to save area.
- Start/busy/done handshake so a controller can launch operations and collect registered results.

Parameters:
- WIDTH, 8, operand and result width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on accepted start.
- B  input  WIDTH  subtrahend; captured on accepted start.
- Bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; Diff/Bout valid.
- Diff  output  WIDTH  difference result, registered.
- Bout  output  1  final borrow-out, registered.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset (any state, including mid-operation):
  - state=IDLE; busy=0, done=0, Diff=0, Bout=0.
  - Internal shift registers, borrow and counter cleared.
  - Any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Load a_sh<=A, b_sh<=B, br<=Bin, cnt<=0, d_sh<=0.
  - Transition to RUN.
  - Diff/Bout keep their previous values until the new DONE.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - Bit cell: d = a_sh[0]^b_sh[0]^br; bnext = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br).
  - d_sh <= {d, d_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1; br <= bnext; cnt++.
- RUN, cnt==WIDTH-1:
  - The final bit is processed on that edge.
  - Same edge: Diff <= final {d, d_sh[WIDTH-1:1]}, Bout <= bnext, done <= 1, state <= DONE.
- DONE: lasts exactly one cycle; next edge clears done and returns to IDLE.
- Latency: start sampled at E0; done is high for the cycle following edge E0+WIDTH.
  - Minimum start-to-start spacing: WIDTH+2 cycles.
- busy: registered; 1 from the cycle after E0 through the DONE cycle inclusive; 0 in IDLE.
- start while busy (RUN or DONE): ignored. No queuing, no effect on the operation in progress.
- Operand inputs A/B/Bin may change freely after E0 without affecting the result.
- Arithmetic: modulo 2^WIDTH.
  - Bout=1 iff A < B+Bin as unsigned values (equivalently {Bout,Diff} = A − B − Bin in WIDTH+1-bit two's complement).
- WIDTH=1 degenerates to a registered full subtractor with 1-cycle RUN.
- cnt width: $clog2(WIDTH) bits, minimum 1.
  - No wrap-around issue, since RUN exits at WIDTH-1.
- Outputs hold their last result indefinitely in IDLE.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, Bin=0, start pulse at E0 → busy rises next cycle; done high exactly in the cycle after E0+8; Diff=0x1E, Bout=0.
- WIDTH=8: A=0x00, B=0x01, Bin=0 → Diff=0xFF, Bout=1. A=0x00, B=0x00, Bin=1 → Diff=0xFF, Bout=1. A=0xFF, B=0xFF, Bin=0 → Diff=0x00, Bout=0.
- Start re-asserted during RUN with different operands (A=0x01, B=0x02), while the 0x5A−0x3C operation runs → ignored; result still 0x1E/0; only one done pulse; a new start accepted only after return to IDLE.
- rst asserted at cycle E0+4 mid-RUN → next cycle busy=0, done=0, Diff=0x00, Bout=0, IDLE. A subsequent start with 0x80−0x01 yields 0x7F, Bout=0 with normal latency.
- WIDTH=1 instance, all 8 (A,B,Bin) combinations → Diff/Bout match the full-subtractor truth table (e.g. 0,1,1 → Diff=0, Bout=1; 1,0,1 → Diff=0, Bout=0). done one cycle after E0+1.
- Back-to-back: start held high continuously, WIDTH=8 → operations accepted every 10 cycles; each done is exactly one cycle wide; Diff is stable between done pulses.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, one full-subtractor cell and a
// borrow flop, LSB first, with start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_nx;
    logic [WIDTH:0] d_cat;
    logic [CW-1:0] cnt;
    logic br, d, bnext, last;
    always_comb begin
        d = a_sh[0] ^ b_sh[0] ^ br;
        bnext = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        d_cat = {d, d_sh};
        d_nx = d_cat[WIDTH:1];
        last = cnt == CW'(WIDTH - 1);
        state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    // Diff/Bout only load on the final bit, so they hold across later starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            {busy, done, Bout, br} <= '0;
            {Diff, a_sh, b_sh, d_sh} <= '0;
            cnt <= '0;
        end else begin
            busy <= state_n != IDLE;
            done <= state_n == DONE;
            if (state == IDLE && start) begin
                a_sh <= A;
                b_sh <= B;
                br <= Bin;
                cnt <= '0;
                d_sh <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                br <= bnext;
                cnt <= cnt + CW'(1);
                d_sh <= d_nx;
                if (last) begin
                    Diff <= d_nx;
                    Bout <= bnext;
                end
            end
        end
    end
endmodule
